alarm_lcd_text_master: RTL

//  Avalon-MM master that drives the LCD 16207 control slave (2-bit address: bit0=RW, bit1=RS;
//  E = read|write). Runs the HD44780 power-on init, then accepts instruction/character bytes on a

---
 rtl/alarm_lcd_text_master.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_lcd_text_master.sv
// alarm_lcd_text_master
//   Avalon-MM master for the LCD 16207 control slave. After reset it waits
//   the power-on delay, writes the HD44780 init bytes {38,38,0C,01,06}, then
//   accepts instruction/character bytes on a valid/ready stream and issues
//   each one as a timed setup / E-pulse / hold / post-write wait.
//
//   Optional feature: define LCD_BUSY_POLL_EN to replace the fixed post-write
//   wait with busy-flag polling (except for the first three init bytes, where
//   the busy flag is not yet valid). Without it the wait is a fixed count,
//   avm_read never asserts and timeout stays 0.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   cmd_valid/cmd_ready byte stream handshake (ready only in IDLE after init)
//   cmd_rs, cmd_data    0=instruction / 1=character, and the byte
//   avm_address         {RS,RW} to the LCD slave
//   avm_read/avm_write  E strobe for busy poll / byte write
//   avm_writedata       byte to the LCD
//   avm_readdata        LCD status, bit7 = busy
//   init_done           init sequence finished (held until reset)
//   timeout             sticky, busy flag never cleared within POLL_LIMIT polls
module alarm_lcd_text_master #(
   parameter int SETUP_CYCLES   = 2,
   parameter int PULSE_CYCLES   = 25,
   parameter int HOLD_CYCLES    = 2,
   parameter int POWERON_CYCLES = 750000,
   parameter int EXEC_CYCLES    = 2500,
   parameter int CLEAR_CYCLES   = 82000,
   parameter int POLL_LIMIT     = 4096
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rs,
   input  logic [7:0] cmd_data,
   output logic [1:0] avm_address,
   output logic       avm_read,
   output logic       avm_write,
   output logic [7:0] avm_writedata,
   input  logic [7:0] avm_readdata,
   output logic       init_done,
   output logic       timeout
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // every count is at least one cycle long
   localparam int SU_N    = max2(SETUP_CYCLES, 1);
   localparam int PU_N    = max2(PULSE_CYCLES, 1);
   localparam int HD_N    = max2(HOLD_CYCLES, 1);
   localparam int POW_N   = max2(POWERON_CYCLES, 1);
   localparam int EXEC_N  = max2(EXEC_CYCLES, 1);
   localparam int CLEAR_N = max2(CLEAR_CYCLES, 1);
   localparam int POLL_N  = max2(POLL_LIMIT, 1);

   // one shared phase timer, wide enough for the longest phase
   localparam int TMAX = max2(max2(max2(POW_N, EXEC_N), max2(CLEAR_N, SU_N)), max2(PU_N, HD_N));
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int PW   = (POLL_N > 1) ? $clog2(POLL_N) : 1;

   typedef enum logic [3:0] {
      PWRON, INIT_LD, SETUP, PULSE, HOLD, WAIT, IDLE, POLL_SU, POLL_PU, POLL_HD
   } state_t;

   function automatic logic [7:0] init_byte(input logic [2:0] i);
      case (i)
         3'd0, 3'd1: return 8'h38;
         3'd2:       return 8'h0C;
         3'd3:       return 8'h01;
         3'd4:       return 8'h06;
         default:    return 8'h00;
      endcase
   endfunction

   state_t          state, state_d;
   logic [TW-1:0]   tmr, tmr_d;
   logic [2:0]      idx, idx_d;       // init bytes loaded so far
   logic [7:0]      byte_q, byte_d;
   logic            rs_q, rs_d;
   logic [PW-1:0]   poll_cnt, poll_d;
   logic            busy_q, busy_d;
   logic            done_d, tmo_d, rdy_d, wr_d, rd_d;
   logic [1:0]      addr_d;
   logic [7:0]      wdata_d;
   logic            exit_wait;
   logic            fixed_only, long_wait;

   // first three init bytes must use the fixed long wait (busy flag invalid)
   assign fixed_only = !init_done && (idx <= 3'd3);
   assign long_wait  = fixed_only || (!rs_q && (byte_q[7:2] == 6'd0) && (byte_q != 8'd0));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= PWRON;
         tmr           <= '0;
         idx           <= '0;
         byte_q        <= '0;
         rs_q          <= 1'b0;
         poll_cnt      <= '0;
         busy_q        <= 1'b0;
         cmd_ready     <= 1'b0;
         avm_address   <= 2'b00;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_writedata <= 8'h00;
         init_done     <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         state         <= state_d;
         tmr           <= tmr_d;
         idx           <= idx_d;
         byte_q        <= byte_d;
         rs_q          <= rs_d;
         poll_cnt      <= poll_d;
         busy_q        <= busy_d;
         cmd_ready     <= rdy_d;
         avm_address   <= addr_d;
         avm_read      <= rd_d;
         avm_write     <= wr_d;
         avm_writedata <= wdata_d;
         init_done     <= done_d;
         timeout       <= tmo_d;
      end
   end

   always_comb begin
      state_d   = state;
      tmr_d     = tmr;
      idx_d     = idx;
      byte_d    = byte_q;
      rs_d      = rs_q;
      poll_d    = poll_cnt;
      busy_d    = busy_q;
      done_d    = init_done;
      tmo_d     = timeout;
      exit_wait = 1'b0;

      case (state)
         PWRON:
            if (tmr == TW'(POW_N - 1)) begin state_d = INIT_LD; tmr_d = '0; end
            else tmr_d = tmr + TW'(1);
         INIT_LD: begin
            byte_d  = init_byte(idx);
            rs_d    = 1'b0;
            idx_d   = idx + 3'd1;
            tmr_d   = '0;
            state_d = SETUP;
         end
         IDLE:
            if (cmd_valid && cmd_ready) begin
               byte_d  = cmd_data;
               rs_d    = cmd_rs;
               tmr_d   = '0;
               state_d = SETUP;
            end
         SETUP:
            if (tmr == TW'(SU_N - 1)) begin state_d = PULSE; tmr_d = '0; end
            else tmr_d = tmr + TW'(1);
         PULSE:
            if (tmr == TW'(PU_N - 1)) begin state_d = HOLD; tmr_d = '0; end
            else tmr_d = tmr + TW'(1);
         HOLD:
            if (tmr == TW'(HD_N - 1)) begin state_d = WAIT; tmr_d = '0; poll_d = '0; end
            else tmr_d = tmr + TW'(1);
         WAIT: begin
`ifdef LCD_BUSY_POLL_EN
            if (!fixed_only) begin
               state_d = POLL_SU;
               tmr_d   = '0;
            end else
`endif
            if (tmr == (long_wait ? TW'(CLEAR_N - 1) : TW'(EXEC_N - 1))) exit_wait = 1'b1;
            else tmr_d = tmr + TW'(1);
         end
         POLL_SU:
            if (tmr == TW'(SU_N - 1)) begin state_d = POLL_PU; tmr_d = '0; end
            else tmr_d = tmr + TW'(1);
         POLL_PU:
            if (tmr == TW'(PU_N - 1)) begin
               busy_d  = avm_readdata[7];   // sampled on the last E-high cycle
               state_d = POLL_HD;
               tmr_d   = '0;
            end else tmr_d = tmr + TW'(1);
         POLL_HD:
            if (tmr == TW'(HD_N - 1)) begin
               tmr_d = '0;
               if (!busy_q) exit_wait = 1'b1;
               else if (poll_cnt == PW'(POLL_N - 1)) begin
                  tmo_d     = 1'b1;
                  exit_wait = 1'b1;
               end else begin
                  poll_d  = poll_cnt + PW'(1);
                  state_d = POLL_SU;
               end
            end else tmr_d = tmr + TW'(1);
         default: state_d = PWRON;
      endcase

      if (exit_wait) begin
         tmr_d = '0;
         if (!init_done && (idx != 3'd5)) state_d = INIT_LD;
         else begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end

      // outputs are registered from the next state so they line up with it
      addr_d  = avm_address;
      wdata_d = avm_writedata;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      case (state_d)
         SETUP:   begin addr_d = {rs_d, 1'b0}; wdata_d = byte_d; end
         PULSE:   wr_d = 1'b1;
         POLL_SU: addr_d = 2'b01;
         POLL_PU: rd_d = 1'b1;
         default: ;
      endcase
      rdy_d = (state_d == IDLE) && done_d;

`ifndef LCD_BUSY_POLL_EN
      rd_d  = 1'b0;
      tmo_d = 1'b0;
`endif
   end

endmodule
